// File: rtl/nubus_arb_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : nubus_arb_sequencer
// Purpose : Master-side NuBus arbitration sequencer: fairness, arbiter settle
//           timing, bus-idle tracking and START/tenure handoff to the master.
// Revision: 1.0  initial release
// ============================================================================
module nubus_arb_sequencer #(
  parameter int ARB_SETTLE = 2,
  parameter int MAX_WAIT   = 255,
  parameter int FAIR       = 1
) (
  input  logic nub_clk,
  input  logic nub_reset,
  input  logic req,
  input  logic done,
  input  logic nub_rqstn,
  input  logic nub_startn,
  input  logic nub_ackn,
  input  logic arb_grant,
  output logic arbcyn,
  output logic rqst_oe,
  output logic start,
  output logic gnt,
  output logic timeout
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FAIR = 3'd1,
    ARB       = 3'd2,
    LOST      = 3'd3,
    WAIT_IDLE = 3'd4,
    OWN       = 3'd5
  } state_t;

  localparam logic [4:0] SETTLE_N = 5'(ARB_SETTLE);
  localparam logic [7:0] WAIT_N   = 8'(MAX_WAIT);

  state_t      state;
  logic        bus_busy;
  logic [4:0]  settle_cnt;
  logic [7:0]  wait_cnt;
  logic [4:0]  settle_inc;
  logic [7:0]  wait_inc;
  logic        wait_hit;

  always_comb begin
    settle_inc = settle_cnt + 5'd1;
    wait_inc   = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
    wait_hit   = (wait_inc >= WAIT_N);
  end

  always_ff @(posedge nub_clk) begin
    if (nub_reset) begin
      state      <= IDLE;
      bus_busy   <= 1'b0;
      settle_cnt <= 5'd0;
      wait_cnt   <= 8'd0;
      arbcyn     <= 1'b1;
      rqst_oe    <= 1'b0;
      start      <= 1'b0;
      gnt        <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      // ACK ends a transaction; a START without ACK opens one.
      if (!nub_ackn)
        bus_busy <= 1'b0;
      else if (!nub_startn)
        bus_busy <= 1'b1;

      start   <= 1'b0;
      timeout <= 1'b0;

      case (state)
        IDLE: begin
          wait_cnt   <= 8'd0;
          settle_cnt <= 5'd0;
          rqst_oe    <= 1'b0;
          arbcyn     <= 1'b1;
          gnt        <= 1'b0;
          if (req) begin
            // The decision edge counts as the first waiting cycle.
            wait_cnt <= 8'd1;
            if (FAIR != 0 && !nub_rqstn) begin
              state <= WAIT_FAIR;
            end else begin
              state   <= ARB;
              rqst_oe <= 1'b1;
              arbcyn  <= 1'b0;
            end
          end
        end

        OWN: begin
          if (done) begin
            gnt   <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          wait_cnt <= wait_inc;
          if (!req || wait_hit) begin
            state   <= IDLE;
            rqst_oe <= 1'b0;
            arbcyn  <= 1'b1;
            timeout <= req;
          end else begin
            case (state)
              WAIT_FAIR: begin
                if (nub_rqstn) begin
                  state      <= ARB;
                  settle_cnt <= 5'd0;
                  rqst_oe    <= 1'b1;
                  arbcyn     <= 1'b0;
                end
              end
              // A START cycle opens a new settle window and is its first cycle.
              ARB: begin
                if (!nub_startn)
                  settle_cnt <= 5'd1;
                else if (settle_inc >= SETTLE_N)
                  state <= arb_grant ? WAIT_IDLE : LOST;
                else
                  settle_cnt <= settle_inc;
              end
              LOST: begin
                if (!nub_startn) begin
                  settle_cnt <= 5'd1;
                  state      <= ARB;
                end
              end
              WAIT_IDLE: begin
                if (!arb_grant) begin
                  state <= LOST;
                end else if (!bus_busy || !nub_ackn) begin
                  state   <= OWN;
                  start   <= 1'b1;
                  gnt     <= 1'b1;
                  rqst_oe <= 1'b0;
                  arbcyn  <= 1'b1;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nubus_arb_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_nubus_arb_sequencer
// Purpose : Directed self-checking bench for nubus_arb_sequencer.
// Revision: 1.0  initial release
// ============================================================================
module tb_nubus_arb_sequencer;

  logic nub_clk, nub_reset, req, done, nub_rqstn, nub_startn, nub_ackn, arb_grant;
  // m_: default parameters, f_: FAIR=0, t_: MAX_WAIT=20
  logic m_arbcyn, m_rqst_oe, m_start, m_gnt, m_timeout;
  logic f_arbcyn, f_rqst_oe, f_start, f_gnt, f_timeout;
  logic t_arbcyn, t_rqst_oe, t_start, t_gnt, t_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] got, exp;

  nubus_arb_sequencer dut_m (
    .nub_clk(nub_clk), .nub_reset(nub_reset), .req(req), .done(done),
    .nub_rqstn(nub_rqstn), .nub_startn(nub_startn), .nub_ackn(nub_ackn),
    .arb_grant(arb_grant), .arbcyn(m_arbcyn), .rqst_oe(m_rqst_oe),
    .start(m_start), .gnt(m_gnt), .timeout(m_timeout));

  nubus_arb_sequencer #(.FAIR(0)) dut_f (
    .nub_clk(nub_clk), .nub_reset(nub_reset), .req(req), .done(done),
    .nub_rqstn(nub_rqstn), .nub_startn(nub_startn), .nub_ackn(nub_ackn),
    .arb_grant(arb_grant), .arbcyn(f_arbcyn), .rqst_oe(f_rqst_oe),
    .start(f_start), .gnt(f_gnt), .timeout(f_timeout));

  nubus_arb_sequencer #(.MAX_WAIT(20)) dut_t (
    .nub_clk(nub_clk), .nub_reset(nub_reset), .req(req), .done(done),
    .nub_rqstn(nub_rqstn), .nub_startn(nub_startn), .nub_ackn(nub_ackn),
    .arb_grant(arb_grant), .arbcyn(t_arbcyn), .rqst_oe(t_rqst_oe),
    .start(t_start), .gnt(t_gnt), .timeout(t_timeout));

  initial nub_clk = 1'b0;
  always #5 nub_clk = ~nub_clk;

  task automatic tick();
    @(posedge nub_clk);
    #1;
  endtask

  // Leaves the bench in "cycle 0": first cycle with reset released.
  task automatic do_reset();
    nub_reset = 1'b1; req = 1'b0; done = 1'b0; nub_rqstn = 1'b1;
    nub_startn = 1'b1; nub_ackn = 1'b1; arb_grant = 1'b1;
    tick(); tick();
    nub_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    got = {m_rqst_oe, m_arbcyn, m_start, m_gnt, m_timeout};
    exp = 5'b01000;
    n_cmp++;
    if (got !== exp) begin
      n_bad++; $display("FAIL reset_values: got %b want %b", got, exp);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    got = {m_rqst_oe, m_arbcyn, m_start, m_gnt, m_timeout};
    n_cmp++;
    if (got !== exp) begin
      n_bad++; $display("FAIL idle_done_ignored: got %b want %b", got, exp);
    end
  endtask

  task automatic test_uncontested();
    do_reset();
    req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {(c >= 1 && c <= 3), !(c >= 1 && c <= 3), (c == 4), (c >= 4 && c <= 10), 1'b0};
      got = {m_rqst_oe, m_arbcyn, m_start, m_gnt, m_timeout};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL uncontested c%0d: got %b want %b", c, got, exp);
      end
      done = (c == 10);
      if (c == 10) req = 1'b0;
    end
  endtask

  task automatic test_fairness();
    do_reset();
    req = 1'b1;
    nub_rqstn = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      n_cmp++;
      if (m_rqst_oe !== (c >= 8)) begin
        n_bad++; $display("FAIL fair_rqst_oe c%0d: got %b want %b", c, m_rqst_oe, (c >= 8));
      end
      if (c == 1 || c == 4) begin
        got = {f_rqst_oe, f_arbcyn, f_start, f_gnt, f_timeout};
        exp = (c == 1) ? 5'b10000 : 5'b01110;
        n_cmp++;
        if (got !== exp) begin
          n_bad++; $display("FAIL nofair c%0d: got %b want %b", c, got, exp);
        end
      end
      if (c == 7) nub_rqstn = 1'b1;
    end
  endtask

  task automatic test_loss_retry();
    do_reset();
    req = 1'b1;
    arb_grant = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      exp = {(c <= 8), (c >= 9), (c == 9), (c >= 9), 1'b0};
      got = {m_rqst_oe, m_arbcyn, m_start, m_gnt, m_timeout};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL loss_retry c%0d: got %b want %b", c, got, exp);
      end
      if (c == 6) begin
        nub_startn = 1'b0; nub_ackn = 1'b0;
      end
      if (c == 7) begin
        nub_startn = 1'b1; nub_ackn = 1'b1; arb_grant = 1'b1;
      end
    end
  endtask

  task automatic test_busy_bus();
    do_reset();
    nub_startn = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c >= 2) begin
        exp = {(c <= 7), (c >= 8), (c == 8), (c >= 8), 1'b0};
        got = {m_rqst_oe, m_arbcyn, m_start, m_gnt, m_timeout};
        n_cmp++;
        if (got !== exp) begin
          n_bad++; $display("FAIL busy_bus c%0d: got %b want %b", c, got, exp);
        end
      end
      if (c == 1) begin
        nub_startn = 1'b1; req = 1'b1;
      end
      nub_ackn = (c == 7) ? 1'b0 : 1'b1;
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req = 1'b1;
    arb_grant = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      tick();
      if (c >= 18) begin
        exp = {(c != 20), (c == 20), 1'b0, 1'b0, (c == 20)};
        got = {t_rqst_oe, t_arbcyn, t_start, t_gnt, t_timeout};
        n_cmp++;
        if (got !== exp) begin
          n_bad++; $display("FAIL timeout c%0d: got %b want %b", c, got, exp);
        end
      end
      if (c == 20) begin
        n_cmp++;
        if (m_timeout !== 1'b0 || m_rqst_oe !== 1'b1) begin
          n_bad++; $display("FAIL timeout_default c%0d: got %b%b want 01", c, m_timeout, m_rqst_oe);
        end
      end
    end
  endtask

  task automatic test_reset_tenure();
    do_reset();
    req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      got = {m_rqst_oe, m_arbcyn, m_start, m_gnt, m_timeout};
      exp = (c == 5) ? 5'b01010 : 5'b01000;
      if (c >= 5) begin
        n_cmp++;
        if (got !== exp) begin
          n_bad++; $display("FAIL reset_tenure c%0d: got %b want %b", c, got, exp);
        end
      end
      nub_reset = (c == 5);
      if (c == 6) begin
        req = 1'b0; done = 1'b1;
      end else begin
        done = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = {((c >= 1 && c <= 3) || (c >= 8 && c <= 10)),
             !((c >= 1 && c <= 3) || (c >= 8 && c <= 10)),
             (c == 4 || c == 11), ((c >= 4 && c <= 6) || c >= 11), 1'b0};
      got = {m_rqst_oe, m_arbcyn, m_start, m_gnt, m_timeout};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL back_to_back c%0d: got %b want %b", c, got, exp);
      end
      done = (c == 6);
    end
  endtask

  initial begin
    test_reset();
    test_uncontested();
    test_fairness();
    test_loss_retry();
    test_busy_bus();
    test_timeout();
    test_reset_tenure();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
